axis_pkt_buffer: RTL
====================

# axis_pkt_buffer

Store-and-forward AXI-Stream packet buffer between a byte-stream source (loop-back FIFO or capture logic) and the bulk-IN `s_axis` port of the `ulpi_axis` USB core. Incoming bytes are cut into packets of at most `MAX_PKT` bytes. A packet is released downstream only once complete, so the USB core never underruns mid-packet. An optional idle timeout flushes a partial packet as a short packet.

## Interface
- `WIDTH`, 8: data width in bits.
- `ABITS`, 11: log2 of storage depth; DEPTH = 2^ABITS entries of WIDTH+1 bits (data + last).
- `MAX_PKT`, 512: maximum packet length in beats; requires 1 ≤ MAX_PKT ≤ DEPTH.
- `TIMEOUT`, 0: idle cycles before a partial packet is committed; 0 disables the timeout.

- `clock`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `s_tvalid_i`  in  1  input beat valid.
- `s_tready_o`  out  1  input ready.
- `s_tlast_i`  in  1  input end-of-packet.
- `s_tdata_i`  in  WIDTH  input data.
- `m_tvalid_o`  out  1  output beat valid.
- `m_tready_i`  in  1  output ready.
- `m_tlast_o`  out  1  output end-of-packet.
- `m_tdata_o`  out  WIDTH  output data.
- `level_o`  out  ABITS+1  beats accepted and not yet delivered.
- `pkts_o`  out  ABITS+1  committed packets not yet fully delivered.

## Operation
- Write pointer `wr`, commit pointer `cm`, read pointer `rd`, each ABITS+1 bits wide. All wrap modulo 2^(ABITS+1).
- Accept a beat on `s_tvalid_i && s_tready_o`. The stored last bit is `s_tlast_i || len == MAX_PKT-1`.
- `len` counts beats in the current uncommitted packet:
  - Increments on each accepted beat.
  - Clears on commit.
- Commit on an accepted beat whose stored last bit = 1: `cm <= wr+1`, `len <= 0`, `pkts_o` + 1.
- Timeout (TIMEOUT > 0):
  - The idle counter clears on any accepted beat or whenever `len == 0`. Otherwise it increments.
  - When the idle counter reaches TIMEOUT, rewrite entry `wr-1` with its data (held in a register) and last = 1. This commits `cm <= wr`, clears `len`, and increments `pkts_o`.
  - An accepted beat in the same cycle takes priority and the timeout does not fire.
- Readout:
  - Entries in [rd, cm) are readable.
  - An output stage (synchronous RAM read plus output/skid register) presents them on `m_*`.
  - Sustains 1 beat/cycle with no bubbles within or between committed packets while `m_tready_i` = 1.
- `s_tready_o` = `level_o < DEPTH`, registered.
- Accounting:
  - `level_o` increments on an input handshake and decrements on an output handshake; both in the same cycle leaves it unchanged.
  - `pkts_o` decrements on an output handshake with `m_tlast_o` = 1; a simultaneous commit leaves it unchanged.
- No deadlock: with MAX_PKT ≤ DEPTH, a full buffer always holds at least one committed packet.
- Packets are never zero-length. A `s_tlast_i` beat always carries data.
- Data, order and packet boundaries are preserved exactly. Nothing is dropped or duplicated.

## Timing
- Reset (`rst_n` low, asynchronous):
  - All pointers, counters, `len` and the idle counter clear.
  - `m_tvalid_o`=0, `m_tlast_o`=0, `m_tdata_o`=0, `level_o`=0, `pkts_o`=0, `s_tready_o`=0.
  - `s_tready_o` = 1 from the first rising edge after release.
- First-beat latency: `m_tvalid_o` rises exactly 2 clocks after the edge that accepts the committing beat or the edge on which the timeout fires, given an empty output stage.
- Once asserted, `m_tvalid_o`, `m_tdata_o` and `m_tlast_o` hold stable until the handshake.
- `s_tready_o` deasserts on the edge at which `level_o` becomes DEPTH. It reasserts one edge after the first output handshake.
- Reset mid-packet discards all stored data. Nothing stale appears after release.

## Test plan
- **Short packet.** 3 beats 0xA0, 0xA1, 0xA2 (last), `m_tready_i`=1:
  - `m_tvalid_o` stays 0 until the 0xA2 accept.
  - 2 clocks after that accept, 0xA0..0xA2 appear back-to-back with `m_tlast_o` only on 0xA2.
  - `pkts_o` goes 0→1→0.
- **Forced split.** MAX_PKT=512, TIMEOUT=0, 1030 beats 0..1029 (mod 256), last only on beat 1030:
  - Output packets of 512, 512 and 6 beats.
  - The 6-beat tail is withheld until beat 1030 is accepted.
- **Timeout flush.** TIMEOUT=16, 5 beats with no last, then idle:
  - Commit on the 16th idle cycle.
  - 5-beat packet output with `m_tlast_o` on beat 5.
  - A beat arriving on cycle 15 cancels the flush.
- **Full.** `m_tready_i`=0, stream with last every 64 beats:
  - `s_tready_o` drops after 2048 accepts, with `level_o`=2048 and `pkts_o`=32.
  - One output handshake reasserts `s_tready_o` next edge.
- **Random backpressure.** Random valid/ready on both sides, 10k beats, random packet lengths 1–700: data and boundaries match the reference model.
- **Reset mid-output.** `rst_n` low during the second beat of a packet:
  - All outputs go to their reset values immediately.
  - After release, `m_tvalid_o` stays 0 until a new packet commits.

Source files
------------

// File: rtl/axis_pkt_buffer.sv
// Store-and-forward AXI-Stream packet buffer: input bytes are cut into packets of at most
// MAX_PKT beats and a packet is released downstream only once it is completely stored.
module axis_pkt_buffer #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned ABITS   = 11,
    parameter int unsigned MAX_PKT = 512,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             s_tvalid_i,
    output logic             s_tready_o,
    input  logic             s_tlast_i,
    input  logic [WIDTH-1:0] s_tdata_i,
    output logic             m_tvalid_o,
    input  logic             m_tready_i,
    output logic             m_tlast_o,
    output logic [WIDTH-1:0] m_tdata_o,
    output logic [ABITS:0]   level_o,
    output logic [ABITS:0]   pkts_o
);
    localparam int unsigned DEPTH   = 1 << ABITS;
    localparam int unsigned PW      = ABITS + 1;
    localparam int unsigned EW      = WIDTH + 1;
    localparam int unsigned TW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned TMO_LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam bit          TMO_EN  = (TIMEOUT > 0);

    logic [EW-1:0]    mem [DEPTH];
    logic [PW-1:0]    wr;
    logic [PW-1:0]    cm;
    logic [PW-1:0]    rd;
    logic [PW-1:0]    len;
    logic [TW-1:0]    idle;
    logic [WIDTH-1:0] last_data;
    logic [EW-1:0]    ram_q;
    logic             s1_valid;
    logic [EW-1:0]    skid;
    logic             skid_valid;

    logic             in_fire_c;
    logic             out_fire_c;
    logic             in_last_c;
    logic             tmo_fire_c;
    logic             commit_c;
    logic [1:0]       occ_c;
    logic             rd_issue_c;
    logic [ABITS-1:0] wr_prev_c;
    logic [PW-1:0]    level_nxt_c;
    logic [PW-1:0]    pkts_nxt_c;

    // Handshakes, commit decision and read issue; occ_c counts beats owed to the output stage
    always_comb begin
        in_fire_c   = s_tvalid_i && s_tready_o;
        out_fire_c  = m_tvalid_o && m_tready_i;
        in_last_c   = s_tlast_i || (len == PW'(MAX_PKT - 1));
        tmo_fire_c  = TMO_EN && !in_fire_c && (len != '0) && (idle == TW'(TMO_LIM));
        commit_c    = (in_fire_c && in_last_c) || tmo_fire_c;
        occ_c       = 2'(s1_valid) + 2'(m_tvalid_o) + 2'(skid_valid) - 2'(out_fire_c);
        rd_issue_c  = (rd != cm) && (occ_c < 2'd2);
        wr_prev_c   = wr[ABITS-1:0] - ABITS'(1);
        level_nxt_c = level_o + PW'(in_fire_c) - PW'(out_fire_c);
        pkts_nxt_c  = pkts_o + PW'(commit_c) - PW'(out_fire_c && m_tlast_o);
    end

    // Storage: one write port (beat or timeout rewrite of the newest entry), one sync read port
    always_ff @(posedge clock) begin
        if (in_fire_c)
            mem[wr[ABITS-1:0]] <= {in_last_c, s_tdata_i};
        else if (tmo_fire_c)
            mem[wr_prev_c] <= {1'b1, last_data};
        if (rd_issue_c)
            ram_q <= mem[rd[ABITS-1:0]];
    end

    // Pointers, packet length, idle timer and accounting
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr         <= '0;
            cm         <= '0;
            rd         <= '0;
            len        <= '0;
            idle       <= '0;
            last_data  <= '0;
            level_o    <= '0;
            pkts_o     <= '0;
            s_tready_o <= 1'b0;
            s1_valid   <= 1'b0;
        end else begin
            if (in_fire_c) begin
                wr        <= wr + PW'(1);
                last_data <= s_tdata_i;
            end
            if (commit_c)
                cm <= in_fire_c ? wr + PW'(1) : wr;
            if (commit_c)
                len <= '0;
            else if (in_fire_c)
                len <= len + PW'(1);
            if (in_fire_c || tmo_fire_c || (len == '0))
                idle <= '0;
            else if (TMO_EN)
                idle <= idle + TW'(1);
            if (rd_issue_c)
                rd <= rd + PW'(1);
            s1_valid   <= rd_issue_c;
            level_o    <= level_nxt_c;
            pkts_o     <= pkts_nxt_c;
            s_tready_o <= (level_nxt_c < PW'(DEPTH));
        end
    end

    // Output register plus skid entry so a RAM read in flight always has a landing slot
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            m_tvalid_o <= 1'b0;
            m_tlast_o  <= 1'b0;
            m_tdata_o  <= '0;
            skid       <= '0;
            skid_valid <= 1'b0;
        end else if (!m_tvalid_o || out_fire_c) begin
            if (skid_valid) begin
                {m_tlast_o, m_tdata_o} <= skid;
                m_tvalid_o             <= 1'b1;
                skid_valid             <= s1_valid;
                if (s1_valid)
                    skid <= ram_q;
            end else if (s1_valid) begin
                {m_tlast_o, m_tdata_o} <= ram_q;
                m_tvalid_o             <= 1'b1;
            end else begin
                m_tvalid_o <= 1'b0;
            end
        end else if (s1_valid) begin
            skid       <= ram_q;
            skid_valid <= 1'b1;
        end
    end

endmodule
